rv_fetch_queue: RTL and testbench

- Parametrised instruction-fetch front end for the RV64IF core family; sits between instruction memory and the decode/control path.
- Owns the PC register and issues in-order requests to instruction memory over a valid/ready interface that tolerates variable latency.
- Buffers returned instructions with their addresses in a DEPTH-entry queue and supports redirect (branch/jump) flushes and initial-address loading.

---
 rtl/rv_fetch_queue_if.sv | 39 +++
 rtl/rv_fetch_queue.sv | 120 ++++++++++++
 tb/tb_rv_fetch_queue.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_fetch_queue_if.sv
// rtl/rv_fetch_queue_if.sv - control, imem request/response and instruction stream signals of the fetch queue
// master: the fetch queue itself (drives out_* signals)
// slave:  the surrounding core/memory side (drives in_* signals)
interface rv_fetch_queue_if #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_load_init_addr;
  logic [XLEN-1:0] in_PC;
  logic            in_redirect;
  logic [XLEN-1:0] in_redirect_addr;
  logic            out_imem_req_valid;
  logic            in_imem_req_ready;
  logic [XLEN-1:0] out_imem_addr;
  logic            in_imem_rsp_valid;
  logic [ILEN-1:0] in_imem_rsp_data;
  logic            out_inst_valid;
  logic [ILEN-1:0] out_inst;
  logic [XLEN-1:0] out_inst_addr;
  logic            in_inst_ready;
  logic [CW-1:0]   out_count;

  modport master (
    input  in_load_init_addr, in_PC, in_redirect, in_redirect_addr,
    input  in_imem_req_ready, in_imem_rsp_valid, in_imem_rsp_data, in_inst_ready,
    output out_imem_req_valid, out_imem_addr, out_inst_valid, out_inst,
    output out_inst_addr, out_count
  );

  modport slave (
    output in_load_init_addr, in_PC, in_redirect, in_redirect_addr,
    output in_imem_req_ready, in_imem_rsp_valid, in_imem_rsp_data, in_inst_ready,
    input  out_imem_req_valid, out_imem_addr, out_inst_valid, out_inst,
    input  out_inst_addr, out_count
  );
endinterface

// File: rtl/rv_fetch_queue.sv
// rtl/rv_fetch_queue.sv - instruction fetch front end: PC owner, in-order imem requests, DEPTH-entry instruction queue
// in_Clk : clock, all state on the rising edge
// Rst    : synchronous active-high reset
// bus    : load/redirect controls, imem request/response handshake,
//          instruction head (valid/inst/addr/ready) and occupancy count
module rv_fetch_queue #(
  parameter int XLEN    = 64,
  parameter int ILEN    = 32,
  parameter int DEPTH   = 4,
  parameter int PC_STEP = 4
) (
  input  logic              in_Clk,
  input  logic              Rst,
  rv_fetch_queue_if.master  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   outst;
  logic [CW-1:0]   drop;
  logic [PW-1:0]   q_rd, q_wr, t_rd, t_wr;
  logic [XLEN-1:0] q_addr [DEPTH];
  logic [ILEN-1:0] q_data [DEPTH];
  logic [XLEN-1:0] t_addr [DEPTH];

  logic            flush;
  logic [XLEN-1:0] flush_target;
  logic            req_valid;
  logic [CW:0]     credits_used;
  logic            req_fire, rsp_take, rsp_drop, rsp_push, inst_valid, pop;

  always_ff @(posedge in_Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    flush        = 1'b0;
    flush_target = bus.in_PC;
    req_valid    = 1'b0;
    // Queued entries plus in-flight requests (stale ones included) share DEPTH credits.
    credits_used = {1'b0, occ} + {1'b0, outst};
    case (state)
      IDLE: begin
        if (bus.in_load_init_addr) state_next = RUN;
      end
      RUN: begin
        // Load in RUN is a redirect to in_PC and wins over in_redirect.
        flush        = bus.in_load_init_addr || bus.in_redirect;
        flush_target = bus.in_load_init_addr ? bus.in_PC : bus.in_redirect_addr;
        req_valid    = (credits_used < DEPTH_C) && !flush;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_fire   = req_valid && bus.in_imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_take   = bus.in_imem_rsp_valid && (outst != '0);
  assign rsp_drop   = rsp_take && (drop != '0);
  assign rsp_push   = rsp_take && (drop == '0);
  assign inst_valid = (occ != '0);
  assign pop        = inst_valid && bus.in_inst_ready;

  assign bus.out_imem_req_valid = req_valid;
  assign bus.out_imem_addr      = pc;
  assign bus.out_inst_valid     = inst_valid;
  assign bus.out_inst           = inst_valid ? q_data[q_rd] : '0;
  assign bus.out_inst_addr      = inst_valid ? q_addr[q_rd] : '0;
  assign bus.out_count          = occ;

  always_ff @(posedge in_Clk) begin
    if (Rst) begin
      pc    <= '0;
      occ   <= '0;
      outst <= '0;
      drop  <= '0;
      q_rd  <= '0;
      q_wr  <= '0;
      t_rd  <= '0;
      t_wr  <= '0;
    end else if (state == IDLE) begin
      if (bus.in_load_init_addr) pc <= bus.in_PC;
    end else if (flush) begin
      // Everything still in flight becomes stale; a response landing in this
      // same cycle is already one of them and is simply discarded.
      pc    <= flush_target;
      occ   <= '0;
      q_rd  <= '0;
      q_wr  <= '0;
      t_rd  <= '0;
      t_wr  <= '0;
      outst <= outst - CW'(rsp_take);
      drop  <= outst - CW'(rsp_take);
    end else begin
      if (req_fire) begin
        pc           <= pc + XLEN'(PC_STEP);
        t_addr[t_wr] <= pc;
        t_wr         <= t_wr + PW'(1);
      end
      outst <= outst + CW'(req_fire) - CW'(rsp_take);
      if (rsp_drop) drop <= drop - CW'(1);
      if (rsp_push) begin
        q_addr[q_wr] <= t_addr[t_rd];
        q_data[q_wr] <= bus.in_imem_rsp_data;
        q_wr         <= q_wr + PW'(1);
        t_rd         <= t_rd + PW'(1);
      end
      if (pop) q_rd <= q_rd + PW'(1);
      occ <= occ + CW'(rsp_push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_rv_fetch_queue.sv
// tb/tb_rv_fetch_queue.sv - self-checking bench for rv_fetch_queue with an in-bench queue model
module tb_rv_fetch_queue;
  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

  logic in_Clk = 1'b0;
  logic Rst    = 1'b1;
  always #5 in_Clk = ~in_Clk;

  rv_fetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

  rv_fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .PC_STEP(4)) dut (
    .in_Clk (in_Clk),
    .Rst    (Rst),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en   = 1'b0;
  bit mem_auto = 1'b0;
  logic [63:0] pend [$];

  typedef struct { logic [63:0] addr; bit stale; } fl_t;
  typedef struct { logic [63:0] addr; logic [31:0] data; } ent_t;
  fl_t  m_fl [$];
  ent_t m_q  [$];
  bit          m_run = 1'b0;
  logic [63:0] m_pc  = '0;
  logic        exp_rv;
  fl_t         f;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic mem_drive();
    if (pend.size() > 0) begin
      bus.in_imem_rsp_valid = 1'b1;
      bus.in_imem_rsp_data  = mem_word(pend.pop_front());
    end else begin
      bus.in_imem_rsp_valid = 1'b0;
      bus.in_imem_rsp_data  = '0;
    end
  endtask

  task automatic cyc();
    @(posedge in_Clk);
    #2;
    if (mem_auto) mem_drive();
    else begin
      bus.in_imem_rsp_valid = 1'b0;
      bus.in_imem_rsp_data  = '0;
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.out_inst_valid && n < 20) begin
      cyc();
      n++;
    end
    chk(name, 64'(bus.out_inst_valid), 64'd1);
  endtask

  task automatic quiesce(input logic [63:0] target, input bit use_load);
    bus.in_imem_req_ready = 1'b0;
    if (use_load) begin
      bus.in_load_init_addr = 1'b1;
      bus.in_PC             = target;
      bus.in_redirect       = 1'b1;
      bus.in_redirect_addr  = 64'hBAD0;
    end else begin
      bus.in_redirect      = 1'b1;
      bus.in_redirect_addr = target;
    end
    mem_auto = 1'b1;
    cyc();
    bus.in_load_init_addr = 1'b0;
    bus.in_redirect       = 1'b0;
    repeat (6) cyc();
    #1;
    chk("quiesce_count", 64'(bus.out_count), 64'd0);
  endtask

  // Compare the DUT against the model, record accepted requests for the
  // memory, then advance the model across the coming rising edge.
  always @(negedge in_Clk) begin
    exp_rv = m_run && (m_q.size() + m_fl.size() < DEPTH)
             && !bus.in_redirect && !bus.in_load_init_addr;
    if (chk_en) begin
      chk("req_valid",  64'(bus.out_imem_req_valid), 64'(exp_rv));
      chk("imem_addr",  bus.out_imem_addr, m_pc);
      chk("inst_valid", 64'(bus.out_inst_valid), 64'(m_q.size() != 0));
      chk("count",      64'(bus.out_count), 64'(m_q.size()));
      if (m_q.size() != 0) begin
        chk("inst",      64'(bus.out_inst), 64'(m_q[0].data));
        chk("inst_addr", bus.out_inst_addr, m_q[0].addr);
      end
    end
    if (!Rst && bus.out_imem_req_valid && bus.in_imem_req_ready)
      pend.push_back(bus.out_imem_addr);

    if (Rst) begin
      m_run = 1'b0;
      m_pc  = '0;
      m_q.delete();
      m_fl.delete();
    end else if (!m_run) begin
      if (bus.in_load_init_addr) begin
        m_pc  = bus.in_PC;
        m_run = 1'b1;
      end
    end else if (bus.in_load_init_addr || bus.in_redirect) begin
      if (bus.in_imem_rsp_valid && m_fl.size() > 0) f = m_fl.pop_front();
      foreach (m_fl[i]) m_fl[i].stale = 1'b1;
      m_q.delete();
      m_pc = bus.in_load_init_addr ? bus.in_PC : bus.in_redirect_addr;
    end else begin
      if (m_q.size() > 0 && bus.in_inst_ready) void'(m_q.pop_front());
      if (bus.in_imem_rsp_valid && m_fl.size() > 0) begin
        f = m_fl.pop_front();
        if (!f.stale) m_q.push_back('{f.addr, bus.in_imem_rsp_data});
      end
      if (exp_rv && bus.in_imem_req_ready) begin
        m_fl.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 64'd4;
      end
    end
  end

  initial begin
    int n;
    bus.in_load_init_addr = 1'b0;
    bus.in_PC             = '0;
    bus.in_redirect       = 1'b0;
    bus.in_redirect_addr  = '0;
    bus.in_imem_req_ready = 1'b0;
    bus.in_imem_rsp_valid = 1'b0;
    bus.in_imem_rsp_data  = '0;
    bus.in_inst_ready     = 1'b0;
    Rst = 1'b1;
    cyc();
    cyc();
    chk_en = 1'b1;
    #1;
    chk("rst_req_valid",  64'(bus.out_imem_req_valid), 64'd0);
    chk("rst_imem_addr",  bus.out_imem_addr, 64'd0);
    chk("rst_inst_valid", 64'(bus.out_inst_valid), 64'd0);
    chk("rst_count",      64'(bus.out_count), 64'd0);

    // Redirect in IDLE is ignored.
    Rst = 1'b0;
    bus.in_redirect      = 1'b1;
    bus.in_redirect_addr = 64'h5000;
    cyc();
    bus.in_redirect = 1'b0;
    #1;
    chk("idle_redirect_addr",  bus.out_imem_addr, 64'd0);
    chk("idle_redirect_valid", 64'(bus.out_imem_req_valid), 64'd0);

    // Streaming from 0x1000 with 1-cycle memory latency.
    bus.in_imem_req_ready = 1'b1;
    bus.in_inst_ready     = 1'b1;
    mem_auto              = 1'b1;
    bus.in_load_init_addr = 1'b1;
    bus.in_PC             = 64'h1000;
    cyc();
    bus.in_load_init_addr = 1'b0;
    #1;
    chk("load_req_valid", 64'(bus.out_imem_req_valid), 64'd1);
    chk("load_addr",      bus.out_imem_addr, 64'h1000);
    n = 0;
    while (!bus.out_inst_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("first_latency", 64'(n), 64'd2);
    chk("first_addr",    bus.out_inst_addr, 64'h1000);
    chk("first_data",    64'(bus.out_inst), 64'hDEAD1000);
    repeat (10) cyc();
    #1;
    chk("stream_count", 64'(bus.out_count), 64'd1);

    // Consumer stall: fills to DEPTH, then one pop admits one request.
    quiesce(64'h3000, 1'b0);
    bus.in_inst_ready     = 1'b0;
    bus.in_imem_req_ready = 1'b1;
    repeat (10) cyc();
    #1;
    chk("stall_count",     64'(bus.out_count), 64'd4);
    chk("stall_req_valid", 64'(bus.out_imem_req_valid), 64'd0);
    chk("stall_head",      bus.out_inst_addr, 64'h3000);
    bus.in_inst_ready = 1'b1;
    cyc();
    bus.in_inst_ready = 1'b0;
    #1;
    chk("rel_count",     64'(bus.out_count), 64'd3);
    chk("rel_req_valid", 64'(bus.out_imem_req_valid), 64'd1);
    chk("rel_head",      bus.out_inst_addr, 64'h3004);
    chk("rel_imem_addr", bus.out_imem_addr, 64'h3010);
    repeat (3) cyc();
    #1;
    chk("refill_count", 64'(bus.out_count), 64'd4);
    chk("refill_req",   64'(bus.out_imem_req_valid), 64'd0);

    // Redirect with two requests outstanding.
    quiesce(64'h4000, 1'b0);
    bus.in_inst_ready     = 1'b1;
    mem_auto              = 1'b0;
    bus.in_imem_req_ready = 1'b1;
    cyc();
    cyc();
    bus.in_imem_req_ready = 1'b0;
    bus.in_redirect       = 1'b1;
    bus.in_redirect_addr  = 64'h2000;
    cyc();
    bus.in_redirect       = 1'b0;
    bus.in_imem_req_ready = 1'b1;
    mem_auto              = 1'b1;
    #1;
    chk("redir_inst_valid", 64'(bus.out_inst_valid), 64'd0);
    chk("redir_pc",         bus.out_imem_addr, 64'h2000);
    wait_valid("redir_wait");
    chk("redir_first_addr", bus.out_inst_addr, 64'h2000);
    chk("redir_first_data", 64'(bus.out_inst), 64'hDEAD2000);

    // Response arriving in the redirect cycle is discarded.
    quiesce(64'h5000, 1'b0);
    mem_auto              = 1'b0;
    bus.in_imem_req_ready = 1'b1;
    cyc();
    cyc();
    bus.in_imem_req_ready = 1'b0;
    bus.in_redirect       = 1'b1;
    bus.in_redirect_addr  = 64'h6000;
    mem_drive();
    cyc();
    bus.in_redirect       = 1'b0;
    bus.in_imem_req_ready = 1'b1;
    bus.in_inst_ready     = 1'b1;
    mem_auto              = 1'b1;
    #1;
    chk("same_inst_valid", 64'(bus.out_inst_valid), 64'd0);
    wait_valid("same_wait");
    chk("same_first_addr", bus.out_inst_addr, 64'h6000);
    chk("same_first_data", 64'(bus.out_inst), 64'hDEAD6000);

    // PC wrap; load in RUN wins over a simultaneous redirect.
    quiesce(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    chk("wrap_pc",    bus.out_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_valid", 64'(bus.out_imem_req_valid), 64'd1);
    bus.in_imem_req_ready = 1'b1;
    cyc();
    bus.in_imem_req_ready = 1'b0;
    #1;
    chk("wrap_next_addr", bus.out_imem_addr, 64'd0);
    bus.in_inst_ready = 1'b1;
    wait_valid("wrap_wait");
    chk("wrap_head_addr", bus.out_inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_head_data", 64'(bus.out_inst), 64'h2152FFFC);

    // Reset mid-stream with credits exhausted (2 queued, 2 outstanding).
    quiesce(64'h7000, 1'b0);
    bus.in_inst_ready     = 1'b0;
    mem_auto              = 1'b0;
    bus.in_imem_req_ready = 1'b1;
    repeat (4) cyc();
    bus.in_imem_req_ready = 1'b0;
    mem_drive();
    cyc();
    mem_drive();
    cyc();
    #1;
    chk("pre_rst_count", 64'(bus.out_count), 64'd2);
    Rst = 1'b1;
    cyc();
    #1;
    chk("mid_rst_req_valid",  64'(bus.out_imem_req_valid), 64'd0);
    chk("mid_rst_imem_addr",  bus.out_imem_addr, 64'd0);
    chk("mid_rst_inst_valid", 64'(bus.out_inst_valid), 64'd0);
    chk("mid_rst_inst",       64'(bus.out_inst), 64'd0);
    chk("mid_rst_inst_addr",  bus.out_inst_addr, 64'd0);
    chk("mid_rst_count",      64'(bus.out_count), 64'd0);
    Rst                   = 1'b0;
    mem_auto              = 1'b1;
    bus.in_imem_req_ready = 1'b1;
    repeat (5) cyc();
    #1;
    chk("post_rst_req_valid", 64'(bus.out_imem_req_valid), 64'd0);
    chk("post_rst_count",     64'(bus.out_count), 64'd0);
    bus.in_load_init_addr = 1'b1;
    bus.in_PC             = 64'h8000;
    bus.in_inst_ready     = 1'b1;
    cyc();
    bus.in_load_init_addr = 1'b0;
    wait_valid("reload_wait");
    chk("reload_addr", bus.out_inst_addr, 64'h8000);
    chk("reload_data", 64'(bus.out_inst), 64'hDEAD8000);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
